program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the instruction path: accepts a byte stream and writes the instruction memory that the core fetches from and decodes.
- The byte stream comes from a UART receiver or a debug host, with a valid/ready handshake.
- Assembles little-endian 32-bit words, writes them to consecutive word addresses, and holds the core in reset until the load completes.
- Screens each word's opcode field against the opcode set the control decoder supports, and flags anything outside it.

Parameters:
- ADDR_WIDTH, 8: instruction memory word-address width; depth = 2**ADDR_WIDTH words.
- CNT_WIDTH, 16: width of the word-count header.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- Start_i, input, 1: begin a load; honoured only in IDLE, DONE and ERR.
- Byte_i, input, 8: stream byte.
- Byte_Valid_i, input, 1: Byte_i is valid.
- Byte_Ready_o, output, 1: loader can accept a byte this cycle.
- Mem_Write_o, output, 1: instruction memory write strobe, one cycle per word.
- Mem_Addr_o, output, ADDR_WIDTH: word address.
- Mem_Data_o, output, 32: assembled instruction word.
- Core_Reset_n_o, output, 1: active-low reset to the core; low while loading.
- Busy_o, output, 1: load in progress.
- Done_o, output, 1: load completed successfully.
- Error_o, output, 1: header count exceeds memory depth.
- Illegal_Op_o, output, 1: sticky; some loaded word had an unsupported opcode.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE.
  - All outputs 0, including Core_Reset_n_o (core held).
  - Counters, word index and shift register cleared.
- Reset mid-load: the load is abandoned; no further writes occur.
- Handshake:
  - A byte transfers when Byte_Valid_i && Byte_Ready_o at a rising edge.
  - Byte_Ready_o=1 only in HDR_LO, HDR_HI and DATA.
  - Byte_Valid_i is ignored in every other state.
- Stream format:
  - Count low byte, count high byte (N words).
  - Then 4*N instruction bytes, least-significant byte of each word first.
- States:
  - IDLE: Start_i -> HDR_LO. Core_Reset_n_o=0. Illegal_Op_o cleared on this transition.
  - HDR_LO: on transfer, latch count[7:0] -> HDR_HI.
  - HDR_HI: on transfer, latch count[15:8]. Then:
    - count==0 -> DONE;
    - count > 2**ADDR_WIDTH -> ERR;
    - otherwise -> DATA.
  - DATA:
    - byte index 0..3; byte k goes to word bits [8k+7:8k];
    - after the 4th transfer -> WRITE.
  - WRITE, exactly one cycle:
    - Mem_Write_o=1, Mem_Addr_o=word index, Mem_Data_o=assembled word;
    - Byte_Ready_o=0;
    - word index increments;
    - if new index == count -> DONE, else DATA.
  - DONE: Done_o=1, Core_Reset_n_o=1, Busy_o=0. Start_i -> HDR_LO; Done_o=0 and Core_Reset_n_o=0 on the next cycle.
  - ERR: Error_o=1, Core_Reset_n_o=0. Start_i -> HDR_LO and clears Error_o.
- Busy_o=1 in HDR_LO, HDR_HI, DATA and WRITE.
- Start_i is ignored in any busy state.
- Mem_Addr_o and Mem_Data_o hold their last values outside WRITE.
- Opcode screen:
  - In WRITE, if word[6:0] is not one of R-type 0110011, I-logic 0010011, I-load 0000011 or U (LUI) 0110111, set Illegal_Op_o.
  - The word is still written; the flag is advisory.
- Throughput: at most one word per 5 cycles (4 byte transfers plus 1 WRITE).
- A full-depth load (count == 2**ADDR_WIDTH) ends after address 2**ADDR_WIDTH-1. The index is ADDR_WIDTH+1 bits, so it never wraps.

Decomposition:
- Shared package:
  - opcode localparams (R_TYPE, I_TYPE_LOGIC, I_TYPE_MEMORY, U_TYPE), so the control decoder and the loader screen share one definition;
  - the loader state encoding.
- One natural sub-module: opcode_check (combinational, 7-bit opcode -> supported flag), reusable by the decoder side.

Test Plan:
- Reset, then stream 02 00 | 13 05 10 00 | 33 05 B5 00, with valid held high:
  - WRITE addr 0 data 0x00100513, then addr 1 data 0x00B50533;
  - Done_o=1, Core_Reset_n_o=1, Illegal_Op_o=0.
- Header 00 00 -> DONE two transfers after Start_i, no Mem_Write_o pulse.
- With ADDR_WIDTH=8, header 01 01 (257) -> ERR, Error_o=1, core held, no writes. Then Start_i with header 01 00 plus one word -> Error_o clears, one write to addr 0.
- Word bytes 6F 00 00 00 (JAL) -> written to memory and Illegal_Op_o=1. A new Start_i clears it.
- Byte_Valid_i toggled randomly:
  - data assembled identically;
  - Byte_Ready_o=0 during each WRITE cycle;
  - no byte lost or duplicated.
- Assert reset low after 2 of 4 data bytes -> all outputs 0 next cycle, no write. A fresh load then writes starting at addr 0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared opcode set and loader state encoding
package program_loader_pkg;

  // Opcodes the control decoder supports; the loader screens against the same set.
  localparam logic [6:0] OPC_R_TYPE        = 7'b0110011;
  localparam logic [6:0] OPC_I_TYPE_LOGIC  = 7'b0010011;
  localparam logic [6:0] OPC_I_TYPE_MEMORY = 7'b0000011;
  localparam logic [6:0] OPC_U_TYPE        = 7'b0110111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_LO,
    ST_HDR_HI,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } loader_state_e;

endpackage

// File: rtl/program_loader_opcode_check.sv
// rtl/program_loader_opcode_check.sv - flags whether a 7-bit opcode is in the supported set
module opcode_check
  import program_loader_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       supported_o
);

  assign supported_o = (opcode_i == OPC_R_TYPE)        ||
                       (opcode_i == OPC_I_TYPE_LOGIC)  ||
                       (opcode_i == OPC_I_TYPE_MEMORY) ||
                       (opcode_i == OPC_U_TYPE);

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte stream to instruction memory loader with opcode screen
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  input  logic [7:0]            Byte_i,
  input  logic                  Byte_Valid_i,
  output logic                  Byte_Ready_o,
  output logic                  Mem_Write_o,
  output logic [ADDR_WIDTH-1:0] Mem_Addr_o,
  output logic [31:0]           Mem_Data_o,
  output logic                  Core_Reset_n_o,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic                  Error_o,
  output logic                  Illegal_Op_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  loader_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           shift_q, shift_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  illegal_q, illegal_d;
  logic                  op_ok;
  logic                  xfer;

  opcode_check u_opcode_check (
    .opcode_i    (data_q[6:0]),
    .supported_o (op_ok)
  );

  assign Byte_Ready_o   = (state_q == ST_HDR_LO) || (state_q == ST_HDR_HI) || (state_q == ST_DATA);
  assign Mem_Write_o    = (state_q == ST_WRITE);
  assign Busy_o         = Byte_Ready_o || Mem_Write_o;
  assign Done_o         = (state_q == ST_DONE);
  assign Core_Reset_n_o = (state_q == ST_DONE);
  assign Error_o        = (state_q == ST_ERR);
  assign Illegal_Op_o   = illegal_q;
  assign Mem_Addr_o     = addr_q;
  assign Mem_Data_o     = data_q;
  assign xfer           = Byte_Valid_i && Byte_Ready_o;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    data_d     = data_q;
    illegal_d  = illegal_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (Start_i) begin
          state_d    = ST_HDR_LO;
          count_d    = '0;
          idx_d      = '0;
          byte_idx_d = '0;
          shift_d    = '0;
          illegal_d  = 1'b0;
        end
      end
      ST_HDR_LO: begin
        if (xfer) begin
          count_d[7:0] = Byte_i;
          state_d      = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        if (xfer) begin
          count_d[15:8] = Byte_i;
          if (count_d == '0)               state_d = ST_DONE;
          else if (32'(count_d) > DEPTH)   state_d = ST_ERR;
          else                             state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: shift_d[7:0]   = Byte_i;
            2'd1: shift_d[15:8]  = Byte_i;
            2'd2: shift_d[23:16] = Byte_i;
            default: begin
              // The final byte goes straight into the output word so WRITE can present it.
              addr_d  = idx_q[ADDR_WIDTH-1:0];
              data_d  = {Byte_i, shift_q};
              state_d = ST_WRITE;
            end
          endcase
        end
      end
      ST_WRITE: begin
        idx_d = idx_q + 1'b1;
        if (!op_ok) illegal_d = 1'b1;
        if (CNT_WIDTH'(idx_d) == count_q) state_d = ST_DONE;
        else                              state_d = ST_DATA;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      illegal_q  <= illegal_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start_i;
  logic [7:0]  Byte_i;
  logic        Byte_Valid_i;
  logic        Byte_Ready_o;
  logic        Mem_Write_o;
  logic [7:0]  Mem_Addr_o;
  logic [31:0] Mem_Data_o;
  logic        Core_Reset_n_o;
  logic        Busy_o;
  logic        Done_o;
  logic        Error_o;
  logic        Illegal_Op_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] word;
    logic        exp_illegal;
  } op_vec_t;

  wr_t         exp_q[$];
  logic [31:0] load_q[$];
  op_vec_t     vecs[8];

  program_loader #(.ADDR_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .Start_i        (Start_i),
    .Byte_i         (Byte_i),
    .Byte_Valid_i   (Byte_Valid_i),
    .Byte_Ready_o   (Byte_Ready_o),
    .Mem_Write_o    (Mem_Write_o),
    .Mem_Addr_o     (Mem_Addr_o),
    .Mem_Data_o     (Mem_Data_o),
    .Core_Reset_n_o (Core_Reset_n_o),
    .Busy_o         (Busy_o),
    .Done_o         (Done_o),
    .Error_o        (Error_o),
    .Illegal_Op_o   (Illegal_Op_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset === 1'b1 && Mem_Write_o === 1'b1) begin
      chk("ready_low_in_write", {63'd0, Byte_Ready_o}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'd1, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", {56'd0, Mem_Addr_o}, {56'd0, e.addr});
        chk("write_data", {32'd0, Mem_Data_o}, {32'd0, e.data});
      end
    end
  end

  task automatic do_start();
    Start_i = 1'b1;
    @(posedge clk); #1;
    Start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int guard = 0;
    if (rnd) begin
      while ($urandom_range(0, 2) == 0) begin
        Byte_Valid_i = 1'b0;
        Byte_i       = 8'hXX;
        @(posedge clk); #1;
      end
    end
    Byte_i       = b;
    Byte_Valid_i = 1'b1;
    forever begin
      @(negedge clk);
      if (Byte_Ready_o) begin
        @(posedge clk); #1;
        break;
      end
      guard++;
      if (guard > 20) begin
        chk("ready_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        break;
      end
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (Done_o) break;
      n++;
    end
    chk("done_seen", {63'd0, Done_o}, 64'd1);
    chk("core_released", {63'd0, Core_Reset_n_o}, 64'd1);
    chk("not_busy_done", {63'd0, Busy_o}, 64'd0);
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_load(input bit rnd);
    int n;
    n = load_q.size();
    do_start();
    chk("start_busy", {63'd0, Busy_o}, 64'd1);
    chk("start_clears_err", {63'd0, Error_o}, 64'd0);
    chk("start_clears_illegal", {63'd0, Illegal_Op_o}, 64'd0);
    chk("start_holds_core", {63'd0, Core_Reset_n_o}, 64'd0);
    send_byte(n[7:0], rnd);
    send_byte(n[15:8], rnd);
    for (int k = 0; k < n; k++) begin
      wr_t e;
      e.addr = k[7:0];
      e.data = load_q[k];
      exp_q.push_back(e);
      for (int b = 0; b < 4; b++) send_byte(load_q[k][8*b +: 8], rnd);
    end
    Byte_Valid_i = 1'b0;
    wait_done();
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {57'd0, Byte_Ready_o, Mem_Write_o, Core_Reset_n_o, Busy_o, Done_o, Error_o, Illegal_Op_o}, 64'd0);
    chk({name, "_addr_data"}, {24'd0, Mem_Addr_o, Mem_Data_o}, 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000006F, 1'b1};
    vecs[1] = '{32'h00A28033, 1'b0};
    vecs[2] = '{32'h12345037, 1'b0};
    vecs[3] = '{32'h00412083, 1'b0};
    vecs[4] = '{32'h00001017, 1'b1};
    vecs[5] = '{32'h00208063, 1'b1};
    vecs[6] = '{32'h00000073, 1'b1};
    vecs[7] = '{32'hFFF00013, 1'b0};

    reset = 1'b0; Start_i = 1'b0; Byte_i = 8'h00; Byte_Valid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_state");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Two-word load with valid held high.
    load_q = '{32'h00100513, 32'h00B50533};
    run_load(1'b0);
    chk("illegal_after_legal", {63'd0, Illegal_Op_o}, 64'd0);

    // Zero-count header goes straight to DONE.
    load_q.delete();
    run_load(1'b0);

    // 257 words exceeds depth: ERR, then recovery.
    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    Byte_Valid_i = 1'b0;
    @(negedge clk);
    chk("err_flag", {63'd0, Error_o}, 64'd1);
    chk("err_core_held", {63'd0, Core_Reset_n_o}, 64'd0);
    chk("err_not_busy", {62'd0, Busy_o, Done_o}, 64'd0);
    @(posedge clk); #1;
    load_q = '{32'h00000013};
    run_load(1'b0);

    // Opcode screen table.
    foreach (vecs[i]) begin
      load_q = '{vecs[i].word};
      run_load(1'b0);
      chk($sformatf("illegal_vec%0d", i), {63'd0, Illegal_Op_o}, {63'd0, vecs[i].exp_illegal});
    end

    // Illegal flag stays set after a later legal word.
    load_q = '{32'h0000006F, 32'h00000033};
    run_load(1'b0);
    chk("illegal_sticky", {63'd0, Illegal_Op_o}, 64'd1);

    // Random valid gaps.
    load_q.delete();
    for (int k = 0; k < 6; k++) load_q.push_back($urandom);
    run_load(1'b1);

    // Reset after two of four data bytes.
    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    reset = 1'b0;
    Byte_Valid_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("midload_reset");
    repeat (6) @(negedge clk);
    chk("midload_no_resume", {63'd0, Busy_o}, 64'd0);
    @(posedge clk); #1;
    load_q = '{32'h00C58633};
    run_load(1'b0);

    // Full-depth load: 256 words ends at address 255.
    load_q.delete();
    for (int k = 0; k < 256; k++) load_q.push_back({$urandom_range(0, 255), 24'h000033});
    run_load(1'b0);
    chk("full_last_addr", {56'd0, Mem_Addr_o}, 64'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
